// File: rtl/timer_pkg.sv
// Shared definitions for the timer reader: FSM states, timer register
// address constants and a saturating-add overflow helper.
package timer_pkg;

  // Session state machine encoding (explicit values keep the encoding stable).
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM_REQ   = 3'd1,
    ST_ARM_WAIT  = 3'd2,
    ST_RUN       = 3'd3,
    ST_STOP_REQ  = 3'd4,
    ST_STOP_WAIT = 3'd5,
    ST_UPDATE    = 3'd6
  } state_t;

  // Cycle-counter register of the timer peripheral.
  localparam logic [31:0] TIMER_COUNTER_ADDR = 32'h0000_0004;

  // Address bits the peripheral decodes to pick one of its registers.
  localparam int unsigned TIMER_SEL_MSB = 5;
  localparam int unsigned TIMER_SEL_LSB = 2;

  // Saturating-add helper: reports whether a + b exceeds the all-ones value
  // of a width-bit field (width <= 64). Callers select all-ones on overflow.
  function automatic logic sat_add_overflows(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int unsigned width);
    logic [64:0] w_sum;
    logic [64:0] w_lim;
    w_sum = {1'b0, a} + {1'b0, b};
    w_lim = (65'd1 << width) - 65'd1;
    return (w_sum > w_lim);
  endfunction

endpackage

// File: rtl/timer_stats_acc.sv
// Measurement statistics: calibration correction, last/min/max, saturating
// sum and count. A clear request always beats a sample update for the
// accumulated statistics, while last/valid still reflect the new sample.
module timer_stats_acc
  import timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SUM_WIDTH  = 48,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned CAL_OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_update,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_raw,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_last,
  output logic [DATA_WIDTH-1:0] o_min,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [SUM_WIDTH-1:0]  o_sum,
  output logic [CNT_WIDTH-1:0]  o_count
);

  localparam logic [DATA_WIDTH-1:0] CAL = DATA_WIDTH'(CAL_OFFSET);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_last;
  logic [DATA_WIDTH-1:0] r_min;
  logic [DATA_WIDTH-1:0] r_max;
  logic [SUM_WIDTH-1:0]  r_sum;
  logic [CNT_WIDTH-1:0]  r_count;

  logic [DATA_WIDTH-1:0] w_corrected;
  logic [SUM_WIDTH-1:0]  w_sum_add;
  logic [SUM_WIDTH-1:0]  w_sum_next;
  logic [CNT_WIDTH-1:0]  w_count_add;
  logic [CNT_WIDTH-1:0]  w_count_next;

  // Raw capture minus read-path overhead, floored at zero.
  assign w_corrected = (i_raw > CAL) ? (i_raw - CAL) : '0;

  assign w_sum_add    = r_sum + SUM_WIDTH'(w_corrected);
  assign w_sum_next   = sat_add_overflows(64'(r_sum), 64'(w_corrected), SUM_WIDTH)
                        ? '1 : w_sum_add;
  assign w_count_add  = r_count + CNT_WIDTH'(1);
  assign w_count_next = sat_add_overflows(64'(r_count), 64'd1, CNT_WIDTH)
                        ? '1 : w_count_add;

  // Register the sample result and update or clear the running statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= '0;
      r_min   <= '1;
      r_max   <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else begin
      r_valid <= i_update;
      if (i_update) begin
        r_last <= w_corrected;
      end
      if (i_clear) begin
        r_min   <= '1;
        r_max   <= '0;
        r_sum   <= '0;
        r_count <= '0;
      end else if (i_update) begin
        if (w_corrected < r_min) r_min <= w_corrected;
        if (w_corrected > r_max) r_max <= w_corrected;
        r_sum   <= w_sum_next;
        r_count <= w_count_next;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_min   = r_min;
  assign o_max   = r_max;
  assign o_sum   = r_sum;
  assign o_count = r_count;

endmodule

// File: rtl/timer_reader.sv
// Bus initiator for the cycle-counter timer. An arm read restarts the timer,
// a stop read captures the elapsed count, which feeds the statistics block.
// The read strobe is registered: ready_in is sampled one cycle before r_en.
module timer_reader
  import timer_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH   = 32,
  parameter int unsigned             ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] TIMER_ADDR   = ADDRESS_BITS'(TIMER_COUNTER_ADDR),
  parameter int unsigned             CAL_OFFSET   = 0,
  parameter int unsigned             TIMEOUT      = 16,
  parameter int unsigned             SUM_WIDTH    = 48,
  parameter int unsigned             CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear_stats,
  output logic                    busy,
  output logic                    meas_valid,
  output logic [DATA_WIDTH-1:0]   meas_last,
  output logic [DATA_WIDTH-1:0]   meas_min,
  output logic [DATA_WIDTH-1:0]   meas_max,
  output logic [SUM_WIDTH-1:0]    meas_sum,
  output logic [CNT_WIDTH-1:0]    meas_count,
  output logic                    timeout_err,
  output logic [ADDRESS_BITS-1:0] address_out,
  output logic                    r_en,
  input  logic [DATA_WIDTH-1:0]   counter_in,
  input  logic                    valid_in,
  input  logic                    ready_in
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_r_en;
  logic                    w_r_en_next;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic                    r_busy;
  logic [TO_W-1:0]         r_to_cnt;
  logic [TO_W-1:0]         w_to_cnt_next;
  logic                    r_pend_stop;
  logic                    w_pend_stop_next;
  logic [DATA_WIDTH-1:0]   r_raw;
  logic [DATA_WIDTH-1:0]   w_raw_next;
  logic                    r_timeout_err;
  logic                    w_timeout_err_next;
  logic                    w_update;

  // Next-state, strobe, timeout and pending-stop decisions.
  always_comb begin
    w_state_next       = r_state;
    w_r_en_next        = 1'b0;
    w_to_cnt_next      = r_to_cnt;
    w_pend_stop_next   = r_pend_stop;
    w_raw_next         = r_raw;
    w_timeout_err_next = r_timeout_err;
    case (r_state)
      ST_IDLE: begin
        // A stop here (alone or alongside start) is dropped.
        if (start) begin
          w_state_next = ST_ARM_REQ;
          w_r_en_next  = ready_in;
        end
      end
      ST_ARM_REQ: begin
        if (stop) w_pend_stop_next = 1'b1;
        if (r_r_en) begin
          w_state_next  = ST_ARM_WAIT;
          w_to_cnt_next = '0;
        end else begin
          w_r_en_next = ready_in;
        end
      end
      ST_ARM_WAIT: begin
        if (stop) w_pend_stop_next = 1'b1;
        if (valid_in) begin
          w_state_next = ST_RUN;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_next       = ST_IDLE;
          w_timeout_err_next = 1'b1;
          w_pend_stop_next   = 1'b0;
        end else begin
          w_to_cnt_next = r_to_cnt + TO_W'(1);
        end
      end
      ST_RUN: begin
        if (stop || r_pend_stop) begin
          w_state_next     = ST_STOP_REQ;
          w_pend_stop_next = 1'b0;
          w_r_en_next      = ready_in;
        end
      end
      ST_STOP_REQ: begin
        if (r_r_en) begin
          w_state_next  = ST_STOP_WAIT;
          w_to_cnt_next = '0;
        end else begin
          w_r_en_next = ready_in;
        end
      end
      ST_STOP_WAIT: begin
        if (valid_in) begin
          w_state_next = ST_UPDATE;
          w_raw_next   = counter_in;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_next       = ST_IDLE;
          w_timeout_err_next = 1'b1;
          w_pend_stop_next   = 1'b0;
        end else begin
          w_to_cnt_next = r_to_cnt + TO_W'(1);
        end
      end
      ST_UPDATE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (clear_stats) w_timeout_err_next = 1'b0;
  end

  // State and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_r_en        <= 1'b0;
      r_addr        <= '0;
      r_busy        <= 1'b0;
      r_to_cnt      <= '0;
      r_pend_stop   <= 1'b0;
      r_raw         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_r_en        <= w_r_en_next;
      r_addr        <= w_r_en_next ? TIMER_ADDR : '0;
      r_busy        <= (w_state_next != ST_IDLE);
      r_to_cnt      <= w_to_cnt_next;
      r_pend_stop   <= w_pend_stop_next;
      r_raw         <= w_raw_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  assign w_update = (r_state == ST_UPDATE);

  timer_stats_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .CAL_OFFSET (CAL_OFFSET)
  ) u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_update (w_update),
    .i_clear  (clear_stats),
    .i_raw    (r_raw),
    .o_valid  (meas_valid),
    .o_last   (meas_last),
    .o_min    (meas_min),
    .o_max    (meas_max),
    .o_sum    (meas_sum),
    .o_count  (meas_count)
  );

  assign busy        = r_busy;
  assign r_en        = r_r_en;
  assign address_out = r_addr;
  assign timeout_err = r_timeout_err;

endmodule
